// File: rtl/aes_seq_ctrl_if.sv
// Host-side request/response bundle between the bus register block and aes_seq_ctrl.
interface aes_seq_ctrl_if;
    logic         req_valid;
    logic         req_ready;
    logic         req_mode;
    logic [127:0] req_key;
    logic [127:0] req_data;
    logic         resp_valid;
    logic         resp_ready;
    logic [127:0] resp_data;
    logic         busy;

    modport master (
        output req_valid, req_mode, req_key, req_data, resp_ready,
        input  req_ready, resp_valid, resp_data, busy
    );

    modport slave (
        input  req_valid, req_mode, req_key, req_data, resp_ready,
        output req_ready, resp_valid, resp_data, busy
    );
endinterface

// File: rtl/aes_seq_ctrl.sv
// Sequencer for the byte-serial AES core: key/data load, start, wait, shift-out, respond.
// Optional last-key cache enabled by defining AES_SEQ_KEYCACHE_EN.
module aes_seq_ctrl #(
    parameter int CORE_LAT = 13,
    parameter int NBYTES   = 16
) (
    input  logic       clk,
    input  logic       rst,
    aes_seq_ctrl_if.slave bus,
    output logic [7:0] aes_din,
    output logic       aes_loadkey,
    output logic       aes_load_shift,
    output logic       aes_staenc,
    output logic       aes_stadec,
    input  logic [7:0] aes_dout
);
    localparam int         WW        = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
    localparam logic [WW-1:0] WAIT_INIT = WW'(CORE_LAT - 1);
    localparam logic [3:0] BC_LAST   = 4'(NBYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LDKEY, S_LDDATA, S_START, S_WAIT, S_SHIFT, S_RESP
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     bc_q, bc_d, bc_nxt;
    logic [WW-1:0]  wait_q, wait_d;
    logic           mode_q, mode_d;
    logic [127:0]   key_q, key_d;
    logic [127:0]   data_q, data_d;
    logic [7:0]     din_q, din_d;
    logic           loadkey_q, loadkey_d;
    logic           load_shift_q, load_shift_d;
    logic           staenc_q, staenc_d;
    logic           stadec_q, stadec_d;
    logic [127:0]   resp_data_q, resp_data_d;
    logic           resp_valid_q, resp_valid_d;
    logic           req_ready_q, req_ready_d;
    logic           busy_q, busy_d;
    logic           key_hit;

`ifdef AES_SEQ_KEYCACHE_EN
    logic [127:0] last_key_q, last_key_d;
    logic         kc_valid_q, kc_valid_d;

    assign key_hit = kc_valid_q && (bus.req_key == last_key_q);

    always_comb begin
        last_key_d = last_key_q;
        kc_valid_d = kc_valid_q;
        if (state_q == S_LDKEY && bc_q == BC_LAST) begin
            last_key_d = key_q;
            kc_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_key_q <= '0;
            kc_valid_q <= 1'b0;
        end else begin
            last_key_q <= last_key_d;
            kc_valid_q <= kc_valid_d;
        end
    end
`else
    assign key_hit = 1'b0;
`endif

    assign bc_nxt = bc_q + 4'd1;

    always_comb begin
        state_d      = state_q;
        bc_d         = bc_q;
        wait_d       = wait_q;
        mode_d       = mode_q;
        key_d        = key_q;
        data_d       = data_q;
        din_d        = din_q;
        loadkey_d    = 1'b0;
        load_shift_d = 1'b0;
        staenc_d     = 1'b0;
        stadec_d     = 1'b0;
        resp_data_d  = resp_data_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    mode_d = bus.req_mode;
                    key_d  = bus.req_key;
                    data_d = bus.req_data;
                    bc_d   = 4'd0;
                    if (key_hit) begin
                        state_d      = S_LDDATA;
                        load_shift_d = 1'b1;
                        din_d        = bus.req_data[7:0];
                    end else begin
                        state_d   = S_LDKEY;
                        loadkey_d = 1'b1;
                        din_d     = bus.req_key[7:0];
                    end
                end
            end
            S_LDKEY: begin
                if (bc_q == BC_LAST) begin
                    state_d      = S_LDDATA;
                    bc_d         = 4'd0;
                    load_shift_d = 1'b1;
                    din_d        = data_q[7:0];
                end else begin
                    bc_d      = bc_nxt;
                    loadkey_d = 1'b1;
                    din_d     = key_q[8*bc_nxt +: 8];
                end
            end
            S_LDDATA: begin
                if (bc_q == BC_LAST) begin
                    state_d  = S_START;
                    staenc_d = ~mode_q;
                    stadec_d = mode_q;
                end else begin
                    bc_d         = bc_nxt;
                    load_shift_d = 1'b1;
                    din_d        = data_q[8*bc_nxt +: 8];
                end
            end
            S_START: begin
                state_d = S_WAIT;
                wait_d  = WAIT_INIT;
            end
            S_WAIT: begin
                if (wait_q == '0) begin
                    state_d      = S_SHIFT;
                    bc_d         = 4'd0;
                    load_shift_d = 1'b1;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            S_SHIFT: begin
                resp_data_d[8*bc_q +: 8] = aes_dout;
                if (bc_q == BC_LAST) begin
                    state_d = S_RESP;
                end else begin
                    bc_d         = bc_nxt;
                    // The core's last byte is already on dout, so no shift for it.
                    load_shift_d = (bc_nxt != BC_LAST);
                end
            end
            S_RESP: begin
                if (bus.resp_ready && resp_valid_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        req_ready_d  = (state_d == S_IDLE);
        busy_d       = (state_d != S_IDLE);
        resp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            bc_q         <= 4'd0;
            wait_q       <= '0;
            mode_q       <= 1'b0;
            key_q        <= '0;
            data_q       <= '0;
            din_q        <= 8'd0;
            loadkey_q    <= 1'b0;
            load_shift_q <= 1'b0;
            staenc_q     <= 1'b0;
            stadec_q     <= 1'b0;
            resp_data_q  <= '0;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bc_q         <= bc_d;
            wait_q       <= wait_d;
            mode_q       <= mode_d;
            key_q        <= key_d;
            data_q       <= data_d;
            din_q        <= din_d;
            loadkey_q    <= loadkey_d;
            load_shift_q <= load_shift_d;
            staenc_q     <= staenc_d;
            stadec_q     <= stadec_d;
            resp_data_q  <= resp_data_d;
            resp_valid_q <= resp_valid_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.busy       = busy_q;
    assign aes_din        = din_q;
    assign aes_loadkey    = loadkey_q;
    assign aes_load_shift = load_shift_q;
    assign aes_staenc     = staenc_q;
    assign aes_stadec     = stadec_q;
endmodule

// File: tb/tb_aes_seq_ctrl.sv
// Bench for aes_seq_ctrl: behavioural byte-serial core model plus a result scoreboard.
module tb_aes_seq_ctrl;
    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_A  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_A  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_B  = 128'h00112233445566778899aabbccddeeff;

`ifdef AES_SEQ_KEYCACHE_EN
    localparam int LAT_HIT = 46;
    localparam int LK_HIT  = 0;
`else
    localparam int LAT_HIT = 62;
    localparam int LK_HIT  = 16;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] aes_din;
    logic       aes_loadkey, aes_load_shift, aes_staenc, aes_stadec;
    logic [7:0] aes_dout;

    aes_seq_ctrl_if bus ();

    aes_seq_ctrl #(.CORE_LAT(13), .NBYTES(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .aes_din        (aes_din),
        .aes_loadkey    (aes_loadkey),
        .aes_load_shift (aes_load_shift),
        .aes_staenc     (aes_staenc),
        .aes_stadec     (aes_stadec),
        .aes_dout       (aes_dout)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic [127:0] exp_q[$];

    function automatic logic [127:0] ref_fn(input logic [127:0] k, input logic [127:0] d, input logic m);
        if (k == KEY_A && !m && d == PT_A) return CT_A;
        if (k == KEY_A && m && d == CT_A) return PT_A;
        return d ^ k ^ {128{m}};
    endfunction

    // Core model: LSB-first shift-in of key/data, result shift-out on load_shift after start.
    logic [127:0] m_key, m_data, m_res, m_start_key, m_start_data;
    logic         m_done;
    int           n_lk = 0, n_enc = 0, n_dec = 0;

    assign aes_dout = m_res[7:0];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_key  <= '0;
            m_data <= '0;
            m_res  <= '0;
            m_done <= 1'b0;
        end else begin
            if (aes_loadkey) begin
                m_key <= {aes_din, m_key[127:8]};
                n_lk  <= n_lk + 1;
            end
            if (aes_staenc || aes_stadec) begin
                m_res        <= ref_fn(m_key, m_data, aes_stadec);
                m_done       <= 1'b1;
                m_start_key  <= m_key;
                m_start_data <= m_data;
                n_enc        <= n_enc + (aes_staenc ? 1 : 0);
                n_dec        <= n_dec + (aes_stadec ? 1 : 0);
            end else if (aes_load_shift && m_done) begin
                m_res <= {8'h00, m_res[127:8]};
            end else if (aes_load_shift) begin
                m_data <= {aes_din, m_data[127:8]};
            end
            if (bus.resp_valid) m_done <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst) begin
            chk("excl_enc_dec", 128'(aes_staenc & aes_stadec), '0);
            chk("excl_lk_ls", 128'(aes_loadkey & aes_load_shift), '0);
            chk("ready_while_busy", 128'(bus.req_ready & bus.busy), '0);
        end
    endtask

    task automatic do_req(input string tag, input logic [127:0] key, input logic [127:0] data,
                          input logic mode, input int exp_lat, input int exp_lk, input int hold);
        int n;
        int lk0, enc0, dec0;
        logic [127:0] got;
        exp_q.push_back(ref_fn(key, data, mode));
        tick();
        lk0 = n_lk; enc0 = n_enc; dec0 = n_dec;
        bus.req_valid  = 1'b1;
        bus.req_key    = key;
        bus.req_data   = data;
        bus.req_mode   = mode;
        bus.resp_ready = (hold == 0);
        n = 0;
        while (!bus.req_ready && n < 100) begin tick(); n++; end
        chk({tag, "_accept_timeout"}, 128'(n < 100), 128'd1);
        @(posedge clk);
        tick();
        bus.req_valid = 1'b0;
        bus.req_key   = ~key;
        bus.req_data  = ~data;
        bus.req_mode  = ~mode;
        n = 0;
        while (!bus.resp_valid && n < 200) begin tick(); n++; end
        chk({tag, "_latency"}, 128'(n), 128'(exp_lat));
        got = bus.resp_data;
        chk({tag, "_resp_data"}, got, exp_q.pop_front());
        chk({tag, "_loadkey_cycles"}, 128'(n_lk - lk0), 128'(exp_lk));
        chk({tag, "_staenc_pulses"}, 128'(n_enc - enc0), 128'(!mode));
        chk({tag, "_stadec_pulses"}, 128'(n_dec - dec0), 128'(mode));
        chk({tag, "_core_key"}, m_start_key, key);
        chk({tag, "_core_data"}, m_start_data, data);
        for (int i = 0; i < hold; i++) begin
            bus.req_valid = 1'b1;
            bus.req_key   = KEY_B;
            bus.req_data  = PT_B;
            tick();
            chk({tag, "_bp_valid"}, 128'(bus.resp_valid), 128'd1);
            chk({tag, "_bp_data"}, bus.resp_data, got);
            chk({tag, "_bp_ready"}, 128'(bus.req_ready), 128'd0);
            chk({tag, "_bp_busy"}, 128'(bus.busy), 128'd1);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        tick();
        chk({tag, "_resp_done"}, 128'(bus.resp_valid), 128'd0);
        chk({tag, "_ready_after"}, 128'(bus.req_ready), 128'd1);
    endtask

    initial begin
        int n;
        rst            = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_mode   = 1'b0;
        bus.req_key    = '0;
        bus.req_data   = '0;
        bus.resp_ready = 1'b1;
        #12;
        chk("rst_controls", 128'({aes_loadkey, aes_load_shift, aes_staenc, aes_stadec}), '0);
        chk("rst_din", 128'(aes_din), '0);
        chk("rst_resp_valid", 128'(bus.resp_valid), '0);
        chk("rst_resp_data", bus.resp_data, '0);
        chk("rst_busy", 128'(bus.busy), '0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("rel_req_ready", 128'(bus.req_ready), 128'd1);

        do_req("enc_fips", KEY_A, PT_A, 1'b0, 62, 16, 0);
        do_req("dec_fips", KEY_A, CT_A, 1'b1, LAT_HIT, LK_HIT, 0);
        do_req("backpressure", KEY_A, PT_A, 1'b0, LAT_HIT, LK_HIT, 10);

        // Abort in the middle of data load (byte 7), then recover.
        tick();
        bus.req_valid = 1'b1;
        bus.req_key   = KEY_B;
        bus.req_data  = PT_A;
        bus.req_mode  = 1'b0;
        n = 0;
        while (!bus.req_ready && n < 100) begin tick(); n++; end
        chk("abort_accept_timeout", 128'(n < 100), 128'd1);
        @(posedge clk);
        tick();
        bus.req_valid = 1'b0;
        repeat (23) @(posedge clk);
        #2;
        chk("abort_in_lddata", 128'({aes_loadkey, aes_load_shift}), 128'b01);
        rst = 1'b0;
        #1;
        chk("abort_controls", 128'({aes_loadkey, aes_load_shift, aes_staenc, aes_stadec}), '0);
        chk("abort_busy", 128'(bus.busy), '0);
        chk("abort_resp_valid", 128'(bus.resp_valid), '0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("abort_req_ready", 128'(bus.req_ready), 128'd1);

        do_req("enc_after_abort", KEY_A, PT_A, 1'b0, 62, 16, 0);
        do_req("enc_same_key", KEY_A, PT_A, 1'b0, LAT_HIT, LK_HIT, 0);
        do_req("enc_new_key", KEY_B, PT_B, 1'b0, 62, 16, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
